rv32_inst_encoder: RTL and testbench
====================================

Name: rv32_inst_encoder

Overview:
- Pipelined RV32I instruction encoder. Takes a format tag, instruction fields and a full 32-bit immediate value, and produces the 32-bit instruction word.
- It is the inverse of the core's immediate generator: the encoded immediate bits land exactly where the decoder extracts them.
- Used by the boot/test instruction-memory loader and self-test sequencer to build instruction streams on chip.
- Valid/ready handshake on both sides, range checking, status counters.

Parameters:
- CNT_W, 16, width of accepted-instruction counter
- ERR_W, 8, width of saturating error counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- in_fmt  in  3  0=R, 1=I, 2=I-shift, 3=S, 4=B, 5=U, 6=J, 7=reserved
- in_opcode  in  7  opcode, placed in [6:0]
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R and I-shift only)
- in_imm  in  32  signed immediate value (U: full upper value)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate out of range, misaligned, or reserved fmt
- enc_count  out  CNT_W  words delivered (wraps)
- err_count  out  ERR_W  words delivered with out_err=1 (saturates at all-ones)

Behaviour:
- Reset: out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0, both stages empty. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight entries; nothing is emitted.

Pipeline:
- Two stages. S1 registers the fields and computes err. S2 assembles the word and drives the out_* registers.
- Latency: 2 cycles from in handshake to out_valid when unstalled.
- Throughput: 1 word per cycle.
- A stage advances when it is empty or the stage after it advances; S2 advances on out_ready.
- in_ready = !s1_valid || s1_advance. in_ready is combinational from out_ready; no other comb paths from in to out.
- Under backpressure at most 2 entries are held. Order is strictly preserved; no drop, no duplication.
- out_instr and out_err are held stable while out_valid && !out_ready.

Field placement:
- All formats: opcode in [6:0].
- rd in [11:7] for R, I, I-shift, U, J.
- funct3 in [14:12] and rs1 in [19:15] for R, I, I-shift, S, B.
- rs2 in [24:20] for R, S, B.
- R: funct7 in [31:25]; imm is ignored.

Immediate placement and range rules (out_err=1 on violation; the word is still encoded from the truncated bits):
- I: [31:20]=imm[11:0]. Range -2048..2047.
- I-shift: [31:25]=funct7, [24:20]=imm[4:0]. Range 0..31.
- S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Range -2048..2047.
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. Range -4096..4094, and imm[0] must be 0.
- U: [31:12]=imm[31:12]. imm[11:0] must be 0.
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Range -1048576..1048574, and imm[0] must be 0.
- Reserved fmt (7): out_instr=0x00000013 (NOP), out_err=1.

Counters:
- Update only on out_valid && out_ready.
- enc_count increments by 1 and wraps.
- err_count increments when out_err=1 and holds at max.

Test Plan:
- fmt I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 -> out_instr 0x00500093, out_err 0, out_valid exactly 2 cycles after the handshake.
- fmt S, opcode 0x23, funct3=2, rs1=1, rs2=2, imm=-4 -> 0xFE20AE23. fmt B, opcode 0x63, funct3=0, rs1=1, rs2=2, imm=8 -> 0x00208463.
- fmt J, opcode 0x6F, rd=1, imm=2048 -> 0x001000EF. fmt U, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7. Loopback each through the core immediate generator and confirm the decoded Imm equals in_imm.
- Error cases: fmt B imm=3 -> out_err 1. fmt I imm=2048 -> out_err 1. fmt I-shift imm=32 -> out_err 1. fmt 7 -> 0x00000013 with err 1. After these 4 deliveries err_count=4. Preload err_count to 0xFF, deliver an error -> stays 0xFF.
- Backpressure: offer 5 back-to-back requests with out_ready=0 for 4 cycles. in_ready drops after 2 accepts. Release out_ready -> all 5 words delivered in order, enc_count=5.
- Assert rst with 2 entries in flight -> out_valid=0 next cycle, counters 0, no stale word emitted afterwards.

Source files
------------

// File: rtl/rv32_inst_encoder.sv
// Two-stage RV32I instruction encoder: S1 captures fields and range-checks the immediate,
// S2 scatters the immediate into the word and holds it until the consumer takes it.
module rv32_inst_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_ISH = 3'd2,
        FMT_S   = 3'd3,
        FMT_B   = 3'd4,
        FMT_U   = 3'd5,
        FMT_J   = 3'd6,
        FMT_RSV = 3'd7
    } fmt_t;

    logic        s1_valid;
    fmt_t        s1_fmt;
    logic [6:0]  s1_opcode;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [31:0] s1_imm;
    logic        s1_err;

    logic        s1_advance;
    logic        s2_advance;
    logic        in_err;
    logic [31:0] enc_word;
    logic signed [31:0] simm;

    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = !s1_valid || s1_advance;
    assign simm       = $signed(in_imm);

    always_comb begin
        in_err = 1'b0;
        case (fmt_t'(in_fmt))
            FMT_R:        in_err = 1'b0;
            FMT_I, FMT_S: in_err = (simm < -32'sd2048) || (simm > 32'sd2047);
            FMT_ISH:      in_err = (in_imm[31:5] != 27'd0);
            FMT_B:        in_err = (simm < -32'sd4096) || (simm > 32'sd4094) || in_imm[0];
            FMT_U:        in_err = (in_imm[11:0] != 12'd0);
            FMT_J:        in_err = (simm < -32'sd1048576) || (simm > 32'sd1048574) || in_imm[0];
            default:      in_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_R;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
            s1_err    <= 1'b0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= fmt_t'(in_fmt);
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_funct7 <= in_funct7;
                s1_imm    <= in_imm;
                s1_err    <= in_err;
            end
        end
    end

    // Bit scatter mirrors the core's immediate generator so decode recovers in_imm exactly.
    always_comb begin
        enc_word = 32'h0000_0013;
        case (s1_fmt)
            FMT_R:   enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_I:   enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_ISH: enc_word = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S:   enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B:   enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                 s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U:   enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J:   enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                 s1_rd, s1_opcode};
            default: enc_word = 32'h0000_0013;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (s2_advance) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= enc_word;
                    out_err   <= s1_err;
                end
            end
            if (out_valid && out_ready) begin
                enc_count <= enc_count + 1'b1;
                if (out_err && (err_count != '1))
                    err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Directed bench for rv32_inst_encoder: field placement, latency, range errors,
// counter saturation, backpressure ordering and mid-flight reset.
module tb_rv32_inst_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;

    rv32_inst_encoder #(.CNT_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Core immediate generator, used to prove encoded bits land where decode expects them.
    function automatic logic [31:0] imm_gen(input logic [2:0] fmt, input logic [31:0] w);
        case (fmt)
            3'd1:    imm_gen = {{20{w[31]}}, w[31:20]};
            3'd3:    imm_gen = {{20{w[31]}}, w[31:25], w[11:7]};
            3'd4:    imm_gen = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd5:    imm_gen = {w[31:12], 12'b0};
            3'd6:    imm_gen = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: imm_gen = 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    endtask

    // Holds the request until it is accepted; returns just after the handshake edge.
    task automatic send(output bit ok);
        bit hs;
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) ok = 1'b1;
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(output logic [31:0] w, output logic e, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        w = 'x;
        e = 1'bx;
        while (!ok && n < 20) begin
            if (out_valid) begin
                w = out_instr;
                e = out_err;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_instr !== 32'h0) begin fails++; $display("[TB] FAIL reset_out_instr: got %h want 00000000", out_instr); end
        tests++; if (out_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_err: got %b want 0", out_err); end
        tests++; if (enc_count !== 16'd0) begin fails++; $display("[TB] FAIL reset_enc_count: got %0d want 0", enc_count); end
        tests++; if (err_count !== 8'd0) begin fails++; $display("[TB] FAIL reset_err_count: got %0d want 0", err_count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_encode();
        logic [2:0]  fmt [4] = '{3'd3, 3'd4, 3'd6, 3'd5};
        logic [6:0]  op  [4] = '{7'h23, 7'h63, 7'h6F, 7'h37};
        logic [4:0]  rd  [4] = '{5'd0, 5'd0, 5'd1, 5'd5};
        logic [4:0]  rs1 [4] = '{5'd1, 5'd1, 5'd0, 5'd0};
        logic [4:0]  rs2 [4] = '{5'd2, 5'd2, 5'd0, 5'd0};
        logic [2:0]  f3  [4] = '{3'd2, 3'd0, 3'd0, 3'd0};
        logic [31:0] imm [4] = '{32'hFFFF_FFFC, 32'd8, 32'd2048, 32'h1234_5000};
        logic [31:0] expw[4] = '{32'hFE20_AE23, 32'h0020_8463, 32'h0010_00EF, 32'h1234_52B7};
        logic [31:0] w;
        logic e;
        bit ok;
        do_reset();
        // Latency: handshake cycle c, word visible in cycle c+2.
        applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        send(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL addi_accept: got %b want 1", ok); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL addi_latency_c1: got %b want 0", out_valid); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL addi_latency_c2: got %b want 1", out_valid); end
        tests++; if (out_instr !== 32'h0050_0093) begin fails++; $display("[TB] FAIL addi_word: got %h want 00500093", out_instr); end
        tests++; if (out_err !== 1'b0) begin fails++; $display("[TB] FAIL addi_err: got %b want 0", out_err); end
        tests++; if (imm_gen(3'd1, out_instr) !== 32'd5) begin fails++; $display("[TB] FAIL addi_loopback: got %h want 00000005", imm_gen(3'd1, out_instr)); end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fmt[i], op[i], rd[i], rs1[i], rs2[i], f3[i], 7'd0, imm[i]);
            send(ok);
            collect(w, e, ok);
            tests++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL enc%0d_timeout: got %b want 1", i, ok); end
            tests++; if (w !== expw[i]) begin fails++; $display("[TB] FAIL enc%0d_word: got %h want %h", i, w, expw[i]); end
            tests++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL enc%0d_err: got %b want 0", i, e); end
            tests++; if (imm_gen(fmt[i], w) !== imm[i]) begin fails++; $display("[TB] FAIL enc%0d_loopback: got %h want %h", i, imm_gen(fmt[i], w), imm[i]); end
        end
        tests++; if (enc_count !== 16'd5) begin fails++; $display("[TB] FAIL enc_count_after_encode: got %0d want 5", enc_count); end
        tests++; if (err_count !== 8'd0) begin fails++; $display("[TB] FAIL err_count_after_encode: got %0d want 0", err_count); end
    endtask

    task automatic test_errors();
        logic [2:0]  fmt [4] = '{3'd4, 3'd1, 3'd2, 3'd7};
        logic [6:0]  op  [4] = '{7'h63, 7'h13, 7'h13, 7'h33};
        logic [2:0]  f3  [4] = '{3'd0, 3'd0, 3'd1, 3'd0};
        logic [31:0] imm [4] = '{32'd3, 32'd2048, 32'd32, 32'd0};
        logic [31:0] expw[4] = '{32'h0000_0163, 32'h8000_0013, 32'h0000_1013, 32'h0000_0013};
        logic [31:0] w;
        logic e;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fmt[i], op[i], 5'd0, 5'd0, 5'd0, f3[i], 7'd0, imm[i]);
            send(ok);
            collect(w, e, ok);
            tests++; if (w !== expw[i]) begin fails++; $display("[TB] FAIL err%0d_word: got %h want %h", i, w, expw[i]); end
            tests++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL err%0d_flag: got %b want 1", i, e); end
        end
        tests++; if (err_count !== 8'd4) begin fails++; $display("[TB] FAIL err_count_four: got %0d want 4", err_count); end
        tests++; if (enc_count !== 16'd4) begin fails++; $display("[TB] FAIL enc_count_four: got %0d want 4", enc_count); end
    endtask

    task automatic test_saturate();
        int acc;
        int n;
        bit hs;
        logic [31:0] w;
        logic e;
        bit ok;
        acc = 0;
        n = 0;
        applyStimulus(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        while (acc < 251 && n < 600) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) acc++;
            n++;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++; if (err_count !== 8'hFF) begin fails++; $display("[TB] FAIL err_count_reach_max: got %0d want 255", err_count); end
        applyStimulus(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000);
        send(ok);
        collect(w, e, ok);
        tests++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL sat_err_flag: got %b want 1", e); end
        tests++; if (err_count !== 8'hFF) begin fails++; $display("[TB] FAIL err_count_saturate: got %0d want 255", err_count); end
        tests++; if (enc_count !== 16'd256) begin fails++; $display("[TB] FAIL enc_count_256: got %0d want 256", enc_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expw[5] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
                                 32'h0040_0213, 32'h0050_0293};
        logic [31:0] got [5];
        int idx;
        int nout;
        int cyc;
        bit hs;
        bit take;
        do_reset();
        out_ready = 1'b0;
        idx = 0;
        nout = 0;
        cyc = 0;
        while (nout < 5 && cyc < 40) begin
            if (cyc == 4) begin
                tests++; if (idx !== 2) begin fails++; $display("[TB] FAIL bp_accepts_stalled: got %0d want 2", idx); end
                tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready_low: got %b want 0", in_ready); end
                tests++; if (out_instr !== expw[0]) begin fails++; $display("[TB] FAIL bp_hold_word: got %h want %h", out_instr, expw[0]); end
                out_ready = 1'b1;
            end
            if (idx < 5)
                applyStimulus(3'd1, 7'h13, 5'(idx + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(idx + 1));
            else
                in_valid = 1'b0;
            @(negedge clk);
            hs = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) got[nout] = out_instr;
            @(posedge clk);
            #1;
            if (hs) idx++;
            if (take) nout++;
            cyc++;
        end
        in_valid = 1'b0;
        tests++; if (nout !== 5) begin fails++; $display("[TB] FAIL bp_delivered: got %0d want 5", nout); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (got[i] !== expw[i]) begin fails++; $display("[TB] FAIL bp_order%0d: got %h want %h", i, got[i], expw[i]); end
        end
        tests++; if (enc_count !== 16'd5) begin fails++; $display("[TB] FAIL bp_enc_count: got %0d want 5", enc_count); end
    endtask

    task automatic test_reset_midflight();
        int acc;
        int stale;
        bit hs;
        out_ready = 1'b0;
        acc = 0;
        applyStimulus(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) acc++;
        end
        in_valid = 1'b0;
        tests++; if (acc !== 2) begin fails++; $display("[TB] FAIL mid_accepts: got %0d want 2", acc); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_inflight: got %b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_out_valid: got %b want 0", out_valid); end
        tests++; if (enc_count !== 16'd0) begin fails++; $display("[TB] FAIL mid_enc_count: got %0d want 0", enc_count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
            @(posedge clk);
            #1;
        end
        tests++; if (stale !== 0) begin fails++; $display("[TB] FAIL mid_stale_words: got %0d want 0", stale); end
        tests++; if (enc_count !== 16'd0) begin fails++; $display("[TB] FAIL mid_enc_after: got %0d want 0", enc_count); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_errors();
        test_saturate();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
